// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS-1 read/write control registers plus a
// read-only counter of committed writes in the last slot.
module axi4_lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [31:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [32*(NUM_REGS-1)-1:0]   ctrl_regs
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned NCTRL  = NUM_REGS - 1;
  localparam int unsigned LAST   = NUM_REGS - 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic                  aw_hold;
  logic                  w_hold;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic [31:0]           regs [NCTRL];
  logic [31:0]           wr_count;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic [31:0]           rd_value;
  logic                  unused_bits;

  // Readys are functions of registered state only
  assign s_axi_awready = ~aw_hold & ~s_axi_bvalid;
  assign s_axi_wready  = ~w_hold & ~s_axi_bvalid;
  assign s_axi_arready = ~s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = (aw_hold | aw_hs) & (w_hold | w_hs);

  // Held beat wins over the live bus; the live bus is used on a same-edge handshake
  assign wr_addr = aw_hold ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_hold ? w_data_q : s_axi_wdata;
  assign wr_strb = w_hold ? w_strb_q : s_axi_wstrb;
  assign wr_idx  = wr_addr[IDX_W+1:2];
  assign wr_ok   = (wr_addr[ADDR_WIDTH-1:IDX_W+2] == '0) && (wr_idx != IDX_W'(LAST));

  assign rd_idx      = s_axi_araddr[IDX_W+1:2];
  assign rd_in_range = (s_axi_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};

  // Read mux: last slot returns the write counter
  always_comb begin
    rd_value = wr_count;
    for (int k = 0; k < int'(NCTRL); k++) begin
      if (rd_idx == IDX_W'(k)) rd_value = regs[k];
    end
  end

  always_comb begin
    ctrl_regs = '0;
    for (int k = 0; k < int'(NCTRL); k++) begin
      ctrl_regs[32*k +: 32] = regs[k];
    end
  end

  // Write address/data holding and B channel
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_hold      <= 1'b0;
      w_hold       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_hold      <= 1'b0;
        w_hold       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) aw_hold <= 1'b1;
        if (w_hs) w_hold <= 1'b1;
        if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Register bank and committed-write counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < int'(NCTRL); k++) regs[k] <= '0;
      wr_count <= '0;
    end else if (commit && wr_ok) begin
      for (int k = 0; k < int'(NCTRL); k++) begin
        if (wr_idx == IDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      wr_count <= wr_count + 32'd1;
    end
  end

  // R channel; reads see pre-commit register values on a colliding edge
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_in_range ? rd_value : 32'd0;
      s_axi_rresp  <= rd_in_range ? OKAY : SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave with hand-computed expectations.
module tb_axi4_lite_reg_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [95:0] ctrl_regs;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4_lite_reg_slave #(.ADDR_WIDTH(32), .NUM_REGS(4)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ctrl_regs(ctrl_regs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; w_lead cycles of W before AW (0 = same cycle)
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    int n;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    s_axi_wvalid = 1'b1;
    if (w_lead > 0) begin
      @(negedge aclk);
      s_axi_wvalid = 1'b0;
      repeat (w_lead - 1) @(negedge aclk);
    end
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("bvalid_latency", 32'(n), 32'd0);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    chk("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge aclk);
    s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;

    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;

    // Reset held 17 cycles
    repeat (17) @(negedge aclk);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_ctrl_or", 32'(|ctrl_regs), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_readys", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    // Full-word write, AW and W together
    do_write(32'h0, 32'hDEADBEEF, 4'hF, 0, resp);
    chk("wr0_bresp", 32'(resp), 32'd0);
    chk("wr0_reg0", ctrl_regs[31:0], 32'hDEADBEEF);
    do_read(32'h0, data, resp);
    chk("rd0_data", data, 32'hDEADBEEF);
    chk("rd0_rresp", 32'(resp), 32'd0);

    // Byte-lane writes, W ahead of AW
    do_write(32'h4, 32'h0000BEEF, 4'h3, 3, resp);
    chk("wr1_bresp", 32'(resp), 32'd0);
    chk("wr1_reg1_lo", ctrl_regs[63:32], 32'h0000BEEF);
    do_write(32'h5, 32'hDEAD0000, 4'hC, 0, resp);
    chk("wr1_reg1_hi", ctrl_regs[63:32], 32'hDEADBEEF);
    do_read(32'hC, data, resp);
    chk("rd_count3", data, 32'd3);
    chk("rd_count3_rresp", 32'(resp), 32'd0);

    // Error paths
    do_write(32'hC, 32'h55555555, 4'hF, 0, resp);
    chk("wr_ro_bresp", 32'(resp), 32'd2);
    do_write(32'h40, 32'h66666666, 4'hF, 1, resp);
    chk("wr_oor_bresp", 32'(resp), 32'd2);
    chk("wr_err_regs_unchanged", ctrl_regs[63:32] ^ ctrl_regs[31:0], 32'hDEADBEEF ^ 32'hDEADBEEF);
    chk("wr_err_reg2", ctrl_regs[95:64], 32'd0);
    do_read(32'hC, data, resp);
    chk("rd_count_after_err", data, 32'd3);
    do_read(32'h40, data, resp);
    chk("rd_oor_rresp", 32'(resp), 32'd2);
    chk("rd_oor_rdata", data, 32'd0);

    // B backpressure with a second AW pending
    s_axi_awaddr = 32'h8; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hAAAA5555; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    s_axi_awaddr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("bp_bresp", 32'(s_axi_bresp), 32'd0);
      chk("bp_readys", {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
      @(negedge aclk);
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    chk("bp_bvalid_clr", 32'(s_axi_bvalid), 32'd0);
    chk("bp_aw_not_taken", 32'(s_axi_awready), 32'd1);
    chk("bp_reg2", ctrl_regs[95:64], 32'hAAAA5555);
    s_axi_wdata = 32'h12345678; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("bp2_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("bp2_reg0", ctrl_regs[31:0], 32'h12345678);
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;

    // R backpressure
    s_axi_araddr = 32'h8; s_axi_arvalid = 1'b1;
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rbp_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rbp_rdata", s_axi_rdata, 32'hAAAA5555);
      chk("rbp_arready", 32'(s_axi_arready), 32'd0);
      @(negedge aclk);
    end
    s_axi_rready = 1'b1;
    @(negedge aclk);
    s_axi_rready = 1'b0;
    chk("rbp_rvalid_clr", 32'(s_axi_rvalid), 32'd0);

    // Read/commit collision on register 2
    do_write(32'h8, 32'h11111111, 4'hF, 0, resp);
    chk("col_pre_reg2", ctrl_regs[95:64], 32'h11111111);
    s_axi_wdata = 32'h22222222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    s_axi_awaddr = 32'h8; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h8; s_axi_arvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    chk("col_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("col_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("col_rdata_old", s_axi_rdata, 32'h11111111);
    chk("col_reg2_new", ctrl_regs[95:64], 32'h22222222);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    do_read(32'h8, data, resp);
    chk("col_rdata_new", data, 32'h22222222);
    do_read(32'hC, data, resp);
    chk("final_count", data, 32'd7);
    chk("final_reg1", ctrl_regs[63:32], 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

AXI4-Lite slave register bank that sits directly downstream of the AXI VIP master in `design_1`. It terminates master write and read bursts into a small bank of 32-bit registers. Registers 0..NUM_REGS-2 are read/write control registers exported to fabric logic. Register NUM_REGS-1 is a read-only counter of committed writes. Byte strobes, out-of-range decode and per-channel handshakes follow AXI4-Lite.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr
- NUM_REGS, 4, register count; power of two, 2..16

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address; bits [1:0] ignored
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address; bits [1:0] ignored
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- ctrl_regs  out  32*(NUM_REGS-1)  register k at bits [32k+31:32k]

## Operation
Decode:
- idx = addr[log2(NUM_REGS)+1:2].
- in_range = addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] == 0.

Write path:
- aw_hold and w_hold latch the address and data/strobe, independently.
- awready = !aw_hold & !bvalid.
- wready = !w_hold & !bvalid.
- AW and W may arrive in either order or in the same cycle.
- Commit edge: the edge where (aw_hold | aw_hs) & (w_hold | w_hs). On that edge:
  - Both holds clear; bvalid <= 1.
  - in_range and idx < NUM_REGS-1: byte i of reg[idx] <= wdata byte i for each wstrb[i]=1; bresp=OKAY; wr_count += 1 (32-bit, wraps FFFFFFFF->0). wstrb=0 still counts as OKAY.
  - idx == NUM_REGS-1 or out of range: no register change, no count increment, bresp=SLVERR.
- bvalid stays high until bready; the next AW/W is accepted the cycle after B completes.

Read path:
- arready = !rvalid.
- On ar_hs, on the same edge: rdata <= value(idx); rresp <= OKAY, or SLVERR with rdata=0 if out of range; rvalid <= 1.
- value(NUM_REGS-1) = wr_count.
- rdata/rresp hold stable while rvalid & !rready. rvalid clears on r_hs.
- Read and write channels are fully independent.
- Same-edge ar_hs and write commit to the same register: read returns the pre-write value.

Reset (areset high, asynchronous):
- All registers, wr_count, holds, bvalid, rvalid, rdata, bresp and rresp go to 0.
- awready/wready/arready read 1 once areset deasserts.
- Reset mid-transaction drops the transaction with no response.

## Timing
- Write latency: bvalid high 1 cycle after the later of the AW/W handshakes.
- Register output updates on that same edge.
- Read latency: rvalid high 1 cycle after the AR handshake.
- Throughput: 1 write per 2 cycles with bready held high; 1 read per 2 cycles with rready held high.
- No combinational path from any valid input to any ready output. Readys depend only on internal state.

## Test plan
- Reset: hold areset 17 cycles -> all outputs 0; after release awready=wready=arready=1.
- Write 0xDEADBEEF to addr 0x0, wstrb=F, AW and W in the same cycle -> bvalid next cycle with bresp=00; ctrl_regs[31:0]=DEADBEEF; read 0x0 -> DEADBEEF, rresp=00.
- Byte-level writes:
  - W 3 cycles before AW, to addr 0x4 with data 0x0000BEEF, wstrb=3 -> reg1=0000BEEF.
  - Then addr 0x5 with data 0xDEAD0000, wstrb=C -> reg1=DEADBEEF.
  - Read 0xC -> wr_count=3.
- Error paths:
  - Write to 0xC -> bresp=10, count unchanged.
  - Write to 0x40 -> bresp=10.
  - Read 0x40 -> rresp=10, rdata=0.
- Backpressure:
  - bready low 5 cycles -> bvalid, bresp and ready state held; second AW is not accepted until B completes.
  - rready low 4 cycles -> rdata stable throughout.
- Collision: reg2=11111111, then ar_hs(0x8) on the same edge as a commit of 22222222 to 0x8 -> rdata=11111111; next read -> 22222222.
